// File: rtl/uart_cmd_pkg.sv
// uart_cmd_pkg: shared state/error encodings and sizing helper for the UART command parser
package uart_cmd_pkg;
    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_LEN, S_DATA, S_CHK, S_COMMIT, S_ERR} state_t;
    typedef enum logic [1:0] {ERR_NONE = 2'b00, ERR_LEN = 2'b01, ERR_CHK = 2'b10, ERR_TMO = 2'b11} err_t;
    localparam logic [7:0] SYNC_DEFAULT = 8'hA5;
    function automatic int idx_w(input int depth);
        return depth > 1 ? $clog2(depth) : 1;
    endfunction
endpackage

// File: rtl/uart_cmd_parser_buf.sv
// uart_cmd_buf: unreset payload register file, one write port and one combinational read port
module uart_cmd_buf #(
    parameter int MAX_LEN = 16,
    parameter int IDX_W   = 4
) (
    input  logic             clk_i,
    input  logic             wr_en_i,
    input  logic [IDX_W-1:0] wr_idx_i,
    input  logic [7:0]       wr_data_i,
    input  logic [IDX_W-1:0] rd_idx_i,
    output logic [7:0]       rd_data_o
);
    logic [7:0] mem_q [MAX_LEN];
    always_ff @(posedge clk_i) begin
        if (wr_en_i) mem_q[wr_idx_i] <= wr_data_i;
    end
    assign rd_data_o = mem_q[rd_idx_i];
endmodule

// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser: frames SYNC/ADDR/LEN/payload/CHK byte streams into register writes,
// buffering the payload so that only checksum-verified frames reach the register bus.
module uart_cmd_parser
    import uart_cmd_pkg::*;
#(
    parameter logic [7:0]       SYNC_BYTE    = SYNC_DEFAULT,
    parameter int               MAX_LEN      = 16,
    parameter int               CNT_W        = 20,
    parameter logic [CNT_W-1:0] TIMEOUT_CLKS = 20'd86800
) (
    input  logic       i_Clock,
    input  logic       i_Reset,
    input  logic       i_Rx_DV,
    input  logic [7:0] i_Rx_Byte,
    output logic       o_Wr_En,
    output logic [7:0] o_Wr_Addr,
    output logic [7:0] o_Wr_Data,
    output logic       o_Pkt_Done,
    output logic       o_Pkt_Err,
    output logic [1:0] o_Err_Code,
    output logic       o_Busy
);
    localparam int               IDX_W     = idx_w(MAX_LEN);
    localparam logic [7:0]       MAX_LEN_B = 8'(MAX_LEN);
    localparam logic [CNT_W-1:0] TMO_LAST  = TIMEOUT_CLKS - CNT_W'(1);

    state_t           state_q, state_d;
    err_t             err_q, err_d;
    logic [7:0]       base_q, base_d, len_q, len_d, idx_q, idx_d, chk_q, chk_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d, buf_we, tmo;
    logic [7:0]       buf_rd;

    uart_cmd_buf #(.MAX_LEN(MAX_LEN), .IDX_W(IDX_W)) u_buf (
        .clk_i     (i_Clock),
        .wr_en_i   (buf_we),
        .wr_idx_i  (idx_q[IDX_W-1:0]),
        .wr_data_i (i_Rx_Byte),
        .rd_idx_i  (idx_q[IDX_W-1:0]),
        .rd_data_o (buf_rd)
    );

    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        base_d  = base_q;
        len_d   = len_q;
        idx_d   = idx_q;
        chk_d   = chk_q;
        done_d  = 1'b0;
        buf_we  = 1'b0;
        cnt_d   = (i_Rx_DV || !(state_q inside {S_ADDR, S_LEN, S_DATA, S_CHK})) ? '0 : cnt_q + CNT_W'(1);
        // an arriving byte always beats the timeout on the same cycle
        tmo     = !i_Rx_DV && cnt_q == TMO_LAST && state_q inside {S_ADDR, S_LEN, S_DATA, S_CHK};
        case (state_q)
            S_IDLE: if (i_Rx_DV && i_Rx_Byte == SYNC_BYTE) begin
                state_d = S_ADDR;
                err_d   = ERR_NONE;
                chk_d   = '0;
            end
            S_ADDR: if (i_Rx_DV) begin
                base_d  = i_Rx_Byte;
                chk_d   = chk_q ^ i_Rx_Byte;
                state_d = S_LEN;
            end
            S_LEN: if (i_Rx_DV) begin
                if (i_Rx_Byte == 8'd0 || i_Rx_Byte > MAX_LEN_B) begin
                    state_d = S_ERR;
                    err_d   = ERR_LEN;
                end else begin
                    len_d   = i_Rx_Byte;
                    chk_d   = chk_q ^ i_Rx_Byte;
                    idx_d   = '0;
                    state_d = S_DATA;
                end
            end
            S_DATA: if (i_Rx_DV) begin
                buf_we  = 1'b1;
                chk_d   = chk_q ^ i_Rx_Byte;
                idx_d   = idx_q + 8'd1;
                state_d = idx_q == len_q - 8'd1 ? S_CHK : S_DATA;
            end
            S_CHK: if (i_Rx_DV) begin
                if (i_Rx_Byte == chk_q) begin
                    state_d = S_COMMIT;
                    idx_d   = '0;
                end else begin
                    state_d = S_ERR;
                    err_d   = ERR_CHK;
                end
            end
            S_COMMIT: begin
                idx_d = idx_q + 8'd1;
                if (idx_q == len_q - 8'd1) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (tmo) begin
            state_d = S_ERR;
            err_d   = ERR_TMO;
        end
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state_q <= S_IDLE;
            err_q   <= ERR_NONE;
            base_q  <= '0;
            len_q   <= '0;
            idx_q   <= '0;
            chk_q   <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            base_q  <= base_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            chk_q   <= chk_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    assign o_Wr_En    = state_q == S_COMMIT;
    assign o_Wr_Addr  = o_Wr_En ? base_q + idx_q : 8'h00;
    assign o_Wr_Data  = o_Wr_En ? buf_rd : 8'h00;
    assign o_Pkt_Done = done_q;
    assign o_Pkt_Err  = state_q == S_ERR;
    assign o_Err_Code = err_q;
    assign o_Busy     = state_q != S_IDLE;
endmodule

// File: tb/tb_uart_cmd_parser.sv
// tb_uart_cmd_parser: table-driven, hand-written and randomized frame checks against a frame-level model
module tb_uart_cmd_parser;
    localparam int TMO = 200;

    logic       clk = 1'b0, rst = 1'b1, dv = 1'b0;
    logic [7:0] rx = 8'h00;
    logic       o_Wr_En, o_Pkt_Done, o_Pkt_Err, o_Busy;
    logic [7:0] o_Wr_Addr, o_Wr_Data;
    logic [1:0] o_Err_Code;

    always #5 clk = ~clk;

    uart_cmd_parser #(.SYNC_BYTE(8'hA5), .MAX_LEN(16), .CNT_W(20), .TIMEOUT_CLKS(20'(TMO))) dut (
        .i_Clock(clk), .i_Reset(rst), .i_Rx_DV(dv), .i_Rx_Byte(rx),
        .o_Wr_En(o_Wr_En), .o_Wr_Addr(o_Wr_Addr), .o_Wr_Data(o_Wr_Data),
        .o_Pkt_Done(o_Pkt_Done), .o_Pkt_Err(o_Pkt_Err), .o_Err_Code(o_Err_Code), .o_Busy(o_Busy)
    );

    int tests = 0, fails = 0;
    logic [15:0] wr_log[$];
    int done_n = 0, err_n = 0, excl_bad = 0;

    always @(negedge clk) begin
        if (o_Wr_En) wr_log.push_back({o_Wr_Addr, o_Wr_Data});
        if (o_Pkt_Done) done_n++;
        if (o_Pkt_Err) err_n++;
        if (int'(o_Wr_En) + int'(o_Pkt_Done) + int'(o_Pkt_Err) > 1) excl_bad++;
    end

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        dv = 1'b1;
        rx = b;
        @(posedge clk);
        #1;
        dv = 1'b0;
        rx = $urandom_range(0, 255);
    endtask

    task automatic gap(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int k;
        for (k = 0; k < 600; k++) begin
            @(negedge clk);
            if (!o_Busy) break;
        end
        check("drain_bound", int'(k < 600), 1);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [0:7][7:0] b;
        int n, code, nwr, done;
        logic [0:1][15:0] w;
    } vec_t;
    vec_t tbl[7];

    int w0, d0, e0, x0;

    task automatic snap();
        w0 = wr_log.size(); d0 = done_n; e0 = err_n; x0 = excl_bad;
    endtask

    // frame-level reference: writes, done pulse, error pulse and final code from the frame contents
    task automatic rand_frame(input int id);
        logic [7:0] q[$];
        logic [7:0] addr, len, chk, p;
        logic [15:0] exp_w[$];
        int code, bad_len, corrupt;
        repeat ($urandom_range(0, 2)) begin
            p = 8'($urandom_range(0, 255));
            q.push_back(p == 8'hA5 ? 8'h5A : p);
        end
        addr = 8'($urandom_range(0, 255));
        len = 8'($urandom_range(0, 18));
        bad_len = int'(len == 0 || len > 16);
        corrupt = int'($urandom_range(0, 3) == 0);
        q.push_back(8'hA5); q.push_back(addr); q.push_back(len);
        chk = addr ^ len;
        if (!bad_len) begin
            for (int i = 0; i < int'(len); i++) begin
                p = 8'($urandom_range(0, 255));
                q.push_back(p);
                chk ^= p;
                exp_w.push_back({8'(addr + 8'(i)), p});
            end
            q.push_back(corrupt ? chk ^ 8'($urandom_range(1, 255)) : chk);
        end
        code = bad_len ? 1 : corrupt ? 2 : 0;
        if (code != 0) exp_w.delete();
        snap();
        foreach (q[i]) begin
            send(q[i]);
            gap($urandom_range(0, 4));
        end
        wait_idle();
        check($sformatf("rnd%0d_nwr", id), wr_log.size() - w0, exp_w.size());
        foreach (exp_w[i]) if (w0 + i < wr_log.size()) check($sformatf("rnd%0d_wr%0d", id, i), int'(wr_log[w0 + i]), int'(exp_w[i]));
        check($sformatf("rnd%0d_done", id), done_n - d0, int'(code == 0));
        check($sformatf("rnd%0d_err", id), err_n - e0, int'(code != 0));
        check($sformatf("rnd%0d_code", id), int'(o_Err_Code), code);
        check($sformatf("rnd%0d_excl", id), excl_bad - x0, 0);
    endtask

    initial begin
        tbl[0] = '{b: {8'hA5, 8'h10, 8'h02, 8'h11, 8'h22, 8'h21, 8'h00, 8'h00}, n: 6, code: 0, nwr: 2, done: 1, w: {16'h1011, 16'h1122}};
        tbl[1] = '{b: {8'hA5, 8'hFF, 8'h02, 8'hAA, 8'hBB, 8'hEC, 8'h00, 8'h00}, n: 6, code: 0, nwr: 2, done: 1, w: {16'hFFAA, 16'h00BB}};
        tbl[2] = '{b: {8'hA5, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, n: 3, code: 1, nwr: 0, done: 0, w: {16'h0, 16'h0}};
        tbl[3] = '{b: {8'hA5, 8'h10, 8'h11, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, n: 3, code: 1, nwr: 0, done: 0, w: {16'h0, 16'h0}};
        tbl[4] = '{b: {8'hA5, 8'h10, 8'h02, 8'h11, 8'h22, 8'h20, 8'h00, 8'h00}, n: 6, code: 2, nwr: 0, done: 0, w: {16'h0, 16'h0}};
        tbl[5] = '{b: {8'hA5, 8'h10, 8'h02, 8'h11, 8'h22, 8'h21, 8'h00, 8'h00}, n: 6, code: 0, nwr: 2, done: 1, w: {16'h1011, 16'h1122}};
        tbl[6] = '{b: {8'h33, 8'hA5, 8'h30, 8'h01, 8'hC3, 8'hF2, 8'h00, 8'h00}, n: 6, code: 0, nwr: 1, done: 1, w: {16'h30C3, 16'h0}};

        gap(3);
        check("rst_wr_en", int'(o_Wr_En), 0);
        check("rst_addr", int'(o_Wr_Addr), 0);
        check("rst_data", int'(o_Wr_Data), 0);
        check("rst_flags", int'({o_Pkt_Done, o_Pkt_Err, o_Busy}), 0);
        check("rst_code", int'(o_Err_Code), 0);
        rst = 1'b0;
        gap(2);

        for (int i = 0; i < 7; i++) begin
            snap();
            for (int j = 0; j < tbl[i].n; j++) begin
                send(tbl[i].b[j]);
                gap(j % 3);
            end
            wait_idle();
            check($sformatf("vec%0d_nwr", i), wr_log.size() - w0, tbl[i].nwr);
            for (int j = 0; j < tbl[i].nwr; j++)
                if (w0 + j < wr_log.size()) check($sformatf("vec%0d_wr%0d", i, j), int'(wr_log[w0 + j]), int'(tbl[i].w[j]));
            check($sformatf("vec%0d_done", i), done_n - d0, tbl[i].done);
            check($sformatf("vec%0d_err", i), err_n - e0, int'(tbl[i].code != 0));
            check($sformatf("vec%0d_code", i), int'(o_Err_Code), tbl[i].code);
            check($sformatf("vec%0d_busy", i), int'(o_Busy), 0);
        end

        // code held after a checksum failure, then cleared by the next SYNC
        send(8'hA5); send(8'h10); send(8'h01); send(8'h55); send(8'h00);
        gap(3);
        check("hold_code", int'(o_Err_Code), 2);
        send(8'hA5);
        check("sync_clears_code", int'(o_Err_Code), 0);
        send(8'h40); send(8'h01); send(8'h99);
        snap();
        send(8'h40 ^ 8'h01 ^ 8'h99);
        check("lat_first_en", int'(o_Wr_En), 1);
        check("lat_first_wr", int'({o_Wr_Addr, o_Wr_Data}), 16'h4099);
        @(posedge clk); #1;
        check("lat_done", int'({o_Wr_En, o_Pkt_Done, o_Busy}), 3'b010);
        @(posedge clk); #1;
        check("lat_done_pulse", int'(o_Pkt_Done), 0);

        send(8'hA5); send(8'h10); send(8'h02); send(8'h11); send(8'h22);
        send(8'h21);
        check("lat_w0", int'({o_Wr_En, o_Wr_Addr, o_Wr_Data}), {1'b1, 16'h1011});
        @(posedge clk); #1;
        check("lat_w1", int'({o_Wr_En, o_Wr_Addr, o_Wr_Data}), {1'b1, 16'h1122});
        @(posedge clk); #1;
        check("lat_w2_done", int'({o_Wr_En, o_Pkt_Done, o_Pkt_Err}), 3'b010);

        gap(2);
        snap();
        send(8'hA5); send(8'h10);
        repeat (TMO - 1) @(posedge clk);
        #1;
        check("tmo_early", int'(o_Pkt_Err), 0);
        @(posedge clk); #1;
        check("tmo_pulse", int'(o_Pkt_Err), 1);
        check("tmo_code", int'(o_Err_Code), 3);
        wait_idle();
        check("tmo_err_count", err_n - e0, 1);
        check("tmo_no_wr", wr_log.size() - w0, 0);

        snap();
        send(8'hA5); send(8'h10);
        repeat (TMO - 1) @(posedge clk);
        #1;
        send(8'h02);
        check("tmo_suppress_err", int'(o_Pkt_Err), 0);
        check("tmo_suppress_busy", int'(o_Busy), 1);
        send(8'h11); send(8'h22); send(8'h21);
        wait_idle();
        check("tmo_suppress_nwr", wr_log.size() - w0, 2);
        check("tmo_suppress_errs", err_n - e0, 0);
        check("tmo_suppress_done", done_n - d0, 1);

        snap();
        send(8'h33); send(8'hA5); send(8'h10); send(8'h04); send(8'h01);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_busy", int'(o_Busy), 0);
        check("midrst_code", int'(o_Err_Code), 0);
        send(8'hA5); send(8'h20); send(8'h01); send(8'h7E); send(8'h5F);
        wait_idle();
        check("midrst_nwr", wr_log.size() - w0, 1);
        if (wr_log.size() > w0) check("midrst_wr", int'(wr_log[w0]), 16'h207E);
        check("midrst_err", err_n - e0, 0);
        check("midrst_done", done_n - d0, 1);

        for (int i = 0; i < 40; i++) rand_frame(i);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/uart_cmd_parser.md
Name: uart_cmd_parser

Overview:
- Sequences the byte stream from the UART receiver into framed write commands for the on-chip register bank.
- Frame format: SYNC, ADDR, LEN, LEN payload bytes, CHK.
- Payload is buffered and written to the register bus only after the checksum passes, so corrupt frames never touch registers.
- Sits between uart_rx (o_Rx_DV/o_Rx_Byte) and the register-file write port.

Parameters:
- SYNC_BYTE, 8'hA5, frame start marker.
- MAX_LEN, 16, maximum payload bytes; buffer depth; range 1..255.
- TIMEOUT_CLKS, 20'd86800, inter-byte timeout in clocks (about 10 byte times at 868 clocks per bit).
- CNT_W, 20, timeout counter width; must hold TIMEOUT_CLKS.

Ports:
- i_Clock  input  1  system clock, same clock as uart_rx.
- i_Reset  input  1  synchronous, active-high reset.
- i_Rx_DV  input  1  one-cycle byte-valid strobe from uart_rx.
- i_Rx_Byte  input  8  received byte, valid when i_Rx_DV=1.
- o_Wr_En  output  1  register write strobe, one cycle per byte.
- o_Wr_Addr  output  8  write address.
- o_Wr_Data  output  8  write data.
- o_Pkt_Done  output  1  one-cycle pulse after the last write of a good frame.
- o_Pkt_Err  output  1  one-cycle pulse when a frame is rejected.
- o_Err_Code  output  2  01 bad LEN, 10 checksum mismatch, 11 timeout; held until the next SYNC is accepted.
- o_Busy  output  1  high in every state except S_IDLE.

Behaviour:
- One clock (i_Clock); reset synchronous, active-high (i_Reset). Reset wins over all other inputs.
- Reset state: all outputs 0, FSM in S_IDLE, buffer index 0, timeout counter 0, running checksum 0. Buffer contents are don't-care.
- Reset mid-frame: the frame is discarded, no writes are issued, and no error is flagged.
- Only i_Rx_DV=1 cycles advance the parse; i_Rx_Byte is ignored otherwise.
- FSM transitions:
  - S_IDLE: byte==SYNC_BYTE -> S_ADDR, clear o_Err_Code and checksum. Any other byte is dropped silently.
  - S_ADDR: latch base address, checksum^=byte -> S_LEN.
  - S_LEN: byte==0 or byte>MAX_LEN -> S_ERR with code 01. Otherwise latch LEN, checksum^=byte, index=0 -> S_DATA.
  - S_DATA: buf[index]=byte, checksum^=byte, index++. When index reaches LEN-1 on a write -> S_CHK.
  - S_CHK: byte==checksum -> S_COMMIT, index=0; else -> S_ERR with code 10.
  - S_COMMIT: one write per cycle. o_Wr_En=1, o_Wr_Addr=base+index (8-bit wrap, FF+1=00), o_Wr_Data=buf[index].
    - Exactly LEN consecutive cycles.
    - On the cycle after the last write: o_Pkt_Done=1 -> S_IDLE.
  - S_ERR: o_Pkt_Err=1 for one cycle -> S_IDLE.
- Checksum: 8-bit XOR of ADDR, LEN and all payload bytes; SYNC is excluded.
- Latency: the first o_Wr_En is registered and asserts on the cycle after the CHK byte's i_Rx_DV. The last write is at +LEN; o_Pkt_Done is at +LEN+1.
- Timeout:
  - Counter clears on every i_Rx_DV and in S_IDLE; it increments in S_ADDR/S_LEN/S_DATA/S_CHK.
  - When it reaches TIMEOUT_CLKS-1 -> S_ERR with code 11.
  - If i_Rx_DV arrives on the same cycle, the byte wins: it is processed and there is no timeout.
- i_Rx_DV during S_COMMIT or S_ERR: the byte is dropped, including SYNC. At 868 clocks/bit no byte can arrive inside a commit of at most 255 cycles, so this is a defensive rule only.
- o_Wr_En, o_Pkt_Done and o_Pkt_Err are mutually exclusive in any cycle.

Decomposition:
- Package uart_cmd_pkg holds:
  - state encodings S_IDLE..S_ERR (3 bits);
  - error codes ERR_NONE=00, ERR_LEN=01, ERR_CHK=10, ERR_TMO=11;
  - default SYNC_BYTE.
- Sub-module uart_cmd_buf: a MAX_LEN x 8 register-file payload buffer.
  - One write port with index, data and enable.
  - Combinational read at the commit index.
  - No reset on storage.

Test Plan:
- Good frame: A5 10 02 11 22 21 -> o_Wr_En at 10<-11 then 11<-22 on consecutive cycles, o_Pkt_Done one cycle later, o_Pkt_Err never.
- Address wrap: A5 FF 02 AA BB EC -> writes FF<-AA, 00<-BB, o_Pkt_Done pulse.
- Bad length: A5 10 00, then separately A5 10 11 (17>MAX_LEN) -> each gives o_Pkt_Err with code 01 after the LEN byte, zero writes, o_Busy drops.
- Bad checksum: A5 10 02 11 22 20 -> o_Pkt_Err with code 10, no o_Wr_En. The following good frame clears the code to 00 at SYNC and writes normally.
- Timeout: A5 10, then idle for TIMEOUT_CLKS -> o_Pkt_Err with code 11 exactly TIMEOUT_CLKS cycles after the 10 strobe. A byte strobe on the final cycle suppresses the timeout.
- Reset mid-frame plus noise: 33 A5 10 04 01 (junk before SYNC), assert i_Reset for 1 cycle during DATA, then A5 20 01 7E 5F -> only write 20<-7E, no error pulses.
